// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM encodings, counter widths
// and parameter legality limits.
package reset_seq_pkg;

  // FSM state encodings; also visible on the debug `state` port
  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_SEQ   = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  // Width of the saturating lock-loss counter
  localparam int LOSS_CNT_W = 8;

  // Parameter legality limits
  localparam int MAX_DOMAINS     = 8;
  localparam int MIN_SYNC_STAGES = 2;

  // Domain index must be able to hold 0..MAX_DOMAINS
  localparam int IDX_W = $clog2(MAX_DOMAINS + 1);

  // Width of the shared hold/step counter: clog2 of the larger period,
  // never less than one bit so a period of 1 still gives a legal vector.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_chain.sv
// sync_chain: STAGES-deep single-bit flop synchroniser with synchronous clear.
// Generic enough to be reused for any slow single-bit CDC input.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the chain; clear empties it
  always_ff @(posedge clk) begin
    if (clr_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: turns an asynchronous MMCM `locked` into NUM_DOMAINS
// staged active-low resets. Lock must stay stable for HOLD_CYCLES before
// domain 0 is released, then one more domain is released every STEP_CYCLES.
// Any loss of lock re-asserts every reset at once.
// Optional feature macro LOCK_LOSS_CNT_EN adds an 8-bit saturating
// lock-loss counter on port `lock_loss_cnt`.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 1000,
  parameter int STEP_CYCLES = 16,
  parameter int NUM_DOMAINS = 3
) (
  input  logic                   clk,
  input  logic                   btnC,
  input  logic                   locked_in,
  output logic [NUM_DOMAINS-1:0] reset_n,
  output logic                   ready,
  output logic [2:0]             state
`ifdef LOCK_LOSS_CNT_EN
  ,
  output logic [LOSS_CNT_W-1:0]  lock_loss_cnt
`endif
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, STEP_CYCLES);
  localparam logic [CNT_W-1:0]       HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]       STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] DOM_ONE   = NUM_DOMAINS'(1);

  logic                   locked_s;
  logic                   lock_lost;
  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [IDX_W-1:0]       idx_q;
  logic [NUM_DOMAINS-1:0] reset_n_q;
  logic                   ready_q;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .clr_i (btnC),
    .d_i   (locked_in),
    .q_o   (locked_s)
  );

  // Lock dropped while a sequence was in progress or complete
  assign lock_lost = !locked_s &&
                     (state_q == S_HOLD || state_q == S_SEQ || state_q == S_RUN);

  // Main sequencing FSM; every output is a register updated here
  always_ff @(posedge clk) begin
    if (btnC) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      idx_q     <= '0;
      reset_n_q <= '0;
      ready_q   <= 1'b0;
    end else if (lock_lost) begin
      // Drop every domain together; ordering only matters on release
      state_q   <= S_WAIT;
      cnt_q     <= '0;
      idx_q     <= '0;
      reset_n_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        S_RESET: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (locked_s) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
          end
        end
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_q     <= '0;
            idx_q     <= IDX_W'(1);
            reset_n_q <= DOM_ONE;
            if (NUM_DOMAINS == 1) begin
              ready_q <= 1'b1;
              state_q <= S_RUN;
            end else begin
              state_q <= S_SEQ;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_SEQ: begin
          if (cnt_q == STEP_LAST) begin
            cnt_q     <= '0;
            idx_q     <= idx_q + IDX_W'(1);
            // Shift in a one so the output stays a thermometer code
            reset_n_q <= (reset_n_q << 1) | DOM_ONE;
            if (idx_q == IDX_LAST) begin
              ready_q <= 1'b1;
              state_q <= S_RUN;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          state_q <= S_RUN;
        end
        default: begin
          state_q   <= S_RESET;
          cnt_q     <= '0;
          idx_q     <= '0;
          reset_n_q <= '0;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign reset_n = reset_n_q;
  assign ready   = ready_q;
  assign state   = state_q;

`ifdef LOCK_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_q;
  logic [LOSS_CNT_W-1:0] loss_d;

  // Saturating increment: sticks at all-ones
  always_comb begin
    loss_d = loss_q;
    if (lock_lost && (loss_q != {LOSS_CNT_W{1'b1}})) begin
      loss_d = loss_q + LOSS_CNT_W'(1);
    end
  end

  // Lock-loss counter; only btnC clears it
  always_ff @(posedge clk) begin
    if (btnC) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign lock_loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer. Two instances share the stimulus:
// A uses the nominal configuration, B the degenerate single-domain one.
// The reference model tracks how many consecutive cycles the FSM has seen
// lock and derives released domains from that run length arithmetically.
module tb_reset_sequencer;

  localparam int SYNC   = 2;
  localparam int HOLD_A = 8;
  localparam int STEP_A = 4;
  localparam int ND_A   = 3;
  localparam int HOLD_B = 1;
  localparam int STEP_B = 4;
  localparam int ND_B   = 1;

  logic            clk = 1'b0;
  logic            btnC = 1'b1;
  logic            locked_in = 1'b0;
  logic [ND_A-1:0] rn_a;
  logic            rdy_a;
  logic [2:0]      st_a;
  logic [ND_B-1:0] rn_b;
  logic            rdy_b;
  logic [2:0]      st_b;
`ifdef LOCK_LOSS_CNT_EN
  logic [7:0]      loss_a;
  logic [7:0]      loss_b;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state, one slot per instance
  bit [7:0] m_sync [2];
  int       m_run  [2];
  int       m_loss [2];
  int       m_state[2];
  int       m_rel  [2];

  always #5 clk = ~clk;

  reset_sequencer #(
    .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD_A), .STEP_CYCLES(STEP_A), .NUM_DOMAINS(ND_A)
  ) dut_a (
    .clk(clk), .btnC(btnC), .locked_in(locked_in),
    .reset_n(rn_a), .ready(rdy_a), .state(st_a)
`ifdef LOCK_LOSS_CNT_EN
    , .lock_loss_cnt(loss_a)
`endif
  );

  reset_sequencer #(
    .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD_B), .STEP_CYCLES(STEP_B), .NUM_DOMAINS(ND_B)
  ) dut_b (
    .clk(clk), .btnC(btnC), .locked_in(locked_in),
    .reset_n(rn_b), .ready(rdy_b), .state(st_b)
`ifdef LOCK_LOSS_CNT_EN
    , .lock_loss_cnt(loss_b)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the behavioural model for instance k
  task automatic model_step(input int k, input int h, input int s, input int n,
                            input bit b, input bit l);
    bit obs;
    int rel;
    if (b) begin
      m_sync[k]  = '0;
      m_run[k]   = 0;
      m_loss[k]  = 0;
      m_state[k] = 0;
      m_rel[k]   = 0;
    end else begin
      obs       = m_sync[k][SYNC-1];
      m_sync[k] = {m_sync[k][6:0], l};
      if (obs) begin
        if (m_run[k] < 1000000) m_run[k]++;
      end else begin
        if (m_run[k] > 0 && m_loss[k] < 255) m_loss[k]++;
        m_run[k] = 0;
      end
      // Domain 0 releases once lock has been seen for h+1 cycles,
      // each further domain s cycles later.
      if (m_run[k] < h + 1) rel = 0;
      else rel = 1 + (m_run[k] - h - 1) / s;
      if (rel > n) rel = n;
      m_rel[k] = rel;
      if (m_run[k] == 0)  m_state[k] = 1;
      else if (rel == 0)  m_state[k] = 2;
      else if (rel < n)   m_state[k] = 3;
      else                m_state[k] = 4;
    end
  endtask

  task automatic compare_all();
    check_val("a.reset_n", {29'd0, rn_a}, (1 << m_rel[0]) - 1);
    check_val("a.ready",   {31'd0, rdy_a}, (m_rel[0] == ND_A) ? 1 : 0);
    check_val("a.state",   {29'd0, st_a}, m_state[0]);
    check_val("b.reset_n", {31'd0, rn_b}, (1 << m_rel[1]) - 1);
    check_val("b.ready",   {31'd0, rdy_b}, (m_rel[1] == ND_B) ? 1 : 0);
    check_val("b.state",   {29'd0, st_b}, m_state[1]);
`ifdef LOCK_LOSS_CNT_EN
    check_val("a.loss", {24'd0, loss_a}, m_loss[0]);
    check_val("b.loss", {24'd0, loss_b}, m_loss[1]);
`endif
  endtask

  // Apply inputs, take one edge, advance the model, sample 1 time unit later
  task automatic step(input bit b, input bit l);
    btnC      = b;
    locked_in = l;
    @(posedge clk);
    model_step(0, HOLD_A, STEP_A, ND_A, b, l);
    model_step(1, HOLD_B, STEP_B, ND_B, b, l);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check_val("reset.reset_n", {29'd0, rn_a}, 0);
    check_val("reset.state",   {29'd0, st_a}, 0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    bit l;
    bit b;

    // Nominal bring-up; iteration k takes edge E+k
    do_reset();
    for (int k = 0; k <= 19; k++) begin
      step(1'b0, 1'b1);
      case (k)
        2:  check_val("nom.b_rn@E+2", {31'd0, rn_b}, 0);
        3: begin
          check_val("nom.b_rn@E+3",  {31'd0, rn_b}, 1);
          check_val("nom.b_rdy@E+3", {31'd0, rdy_b}, 1);
        end
        9:  check_val("nom.rn@E+9",  {29'd0, rn_a}, 0);
        10: check_val("nom.rn@E+10", {29'd0, rn_a}, 1);
        13: check_val("nom.rn@E+13", {29'd0, rn_a}, 1);
        14: check_val("nom.rn@E+14", {29'd0, rn_a}, 3);
        17: check_val("nom.rdy@E+17", {31'd0, rdy_a}, 0);
        18: begin
          check_val("nom.rn@E+18",  {29'd0, rn_a}, 7);
          check_val("nom.rdy@E+18", {31'd0, rdy_a}, 1);
          check_val("nom.st@E+18",  {29'd0, st_a}, 4);
        end
        default: ;
      endcase
    end
    $display("scenario nominal bring-up done (%0d vectors)", vectors);

    // Lock loss in S_RUN; iteration k takes edge F+k
    for (int k = 0; k <= 2; k++) begin
      step(1'b0, 1'b0);
      if (k == 1) check_val("loss.rn@F+1", {29'd0, rn_a}, 7);
      if (k == 2) begin
        check_val("loss.rn@F+2",  {29'd0, rn_a}, 0);
        check_val("loss.rdy@F+2", {31'd0, rdy_a}, 0);
        check_val("loss.st@F+2",  {29'd0, st_a}, 1);
`ifdef LOCK_LOSS_CNT_EN
        check_val("loss.cnt@F+2", {24'd0, loss_a}, 1);
`endif
      end
    end
    $display("scenario lock loss in run done (%0d vectors)", vectors);

    // Hold restart: low for two samples at E+5, E+6
    do_reset();
    for (int k = 0; k <= 18; k++) begin
      step(1'b0, (k == 5 || k == 6) ? 1'b0 : 1'b1);
      if (k == 10) check_val("hold.rn@E+10", {29'd0, rn_a}, 0);
      if (k == 16) check_val("hold.rn@E+16", {29'd0, rn_a}, 0);
      if (k == 17) check_val("hold.rn@E+17", {29'd0, rn_a}, 1);
`ifdef LOCK_LOSS_CNT_EN
      if (k == 18) check_val("hold.cnt", {24'd0, loss_a}, 1);
`endif
    end
    $display("scenario hold restart done (%0d vectors)", vectors);

    // btnC pulse while reset_n = 011, then re-sequence with same latency
    do_reset();
    for (int k = 0; k <= 14; k++) step(1'b0, 1'b1);
    check_val("mid.rn_before", {29'd0, rn_a}, 3);
    step(1'b1, 1'b1);
    check_val("mid.rn_btn", {29'd0, rn_a}, 0);
    check_val("mid.st_btn", {29'd0, st_a}, 0);
`ifdef LOCK_LOSS_CNT_EN
    check_val("mid.cnt_btn", {24'd0, loss_a}, 0);
`endif
    for (int k = 0; k <= 18; k++) begin
      step(1'b0, 1'b1);
      if (k == 9)  check_val("mid.rn@E'+9",  {29'd0, rn_a}, 0);
      if (k == 10) check_val("mid.rn@E'+10", {29'd0, rn_a}, 1);
      if (k == 18) check_val("mid.rn@E'+18", {29'd0, rn_a}, 7);
    end
    $display("scenario btnC mid-sequence done (%0d vectors)", vectors);

    // Saturation: 300 short lock pulses, each ending in a lock loss
    do_reset();
    for (int e = 0; e < 300; e++) begin
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
    end
`ifdef LOCK_LOSS_CNT_EN
    check_val("sat.a", {24'd0, loss_a}, 255);
    check_val("sat.b", {24'd0, loss_b}, 255);
`endif
    $display("scenario saturation done (%0d vectors)", vectors);

    // Randomised lock behaviour with occasional btnC
    do_reset();
    l = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 24) == 0) l = ~l;
      b = ($urandom_range(0, 399) == 0);
      step(b, l);
    end
    $display("scenario random done (%0d vectors)", vectors);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
